wbs_mem_bridge: RTL and testbench
=================================

// Module: wbs_mem_bridge
// PURPOSE
// - Wishbone slave between the Caravel bus (wb_clk_i domain) and the KD-tree accelerator memories/control.
// - Decodes the 0x3000_xxxx-0x3004_xxxx address map and packs 32-bit lower/upper writes into 64-bit leaf/query words.
// - Issues 22-bit node writes, exposes control/status registers and reads back the best-index array.
// PARAMETERS
// - DATA_WIDTH    11  width of one patch element / index
// - NODE_ADDR_W    6  internal-node memory index width (63 nodes, index 0 unused)
// - LEAF_ADDR_W    9  leaf-patch memory index width (64 leaves x 8 patches)
// - QUERY_ADDR_W   9  query-patch memory index width
// - BEST_ADDR_W    9  best-index array index width
// PORTS
// - wb_clk_i      in   1   bus/system clock
// - rst_n         in   1   asynchronous active-low reset
// - wbs_stb_i/wbs_cyc_i/wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write-enable
// - wbs_sel_i     in   4   byte selects; a write with sel!=4'hF is acked and otherwise ignored
// - wbs_adr_i     in   32  byte address
// - wbs_dat_i     in   32  write data
// - wbs_ack_o     out  1   transfer acknowledge
// - wbs_dat_o     out  32  read data, valid while wbs_ack_o=1
// - wbs_mode_o    out  1   MODE reg bit0 (1 = memories are driven from Wishbone)
// - wbs_debug_o   out  1   DEBUG reg bit0
// - fsm_start_o   out  1   one-cycle start pulse to the main FSM
// - fsm_busy_i    in   1   main FSM busy level
// - fsm_done_i    in   1   main FSM done pulse
// - node_wen_o/node_addr_o/node_wdata_o    out  1/NODE_ADDR_W/2*DATA_WIDTH   node write {median,idx}
// - leaf_wen_o/leaf_addr_o/leaf_wdata_o    out  1/LEAF_ADDR_W/64             leaf write
// - query_wen_o/query_addr_o/query_wdata_o out  1/QUERY_ADDR_W/5*DATA_WIDTH  query write (bits 54:0)
// - best_ren_o/best_addr_o  out 1/BEST_ADDR_W  best-array read request
// - best_rdata_i  in   DATA_WIDTH  best-array data, valid the cycle after best_ren_o
// BEHAVIOUR
// - Reset: all outputs 0; MODE, DEBUG, done_sticky, hold_reg, hold_valid, err all cleared.
// - Decode region: wbs_adr_i[31:16]. 0x3000 CSR (MODE 0x0, DEBUG 0x4, DONE 0x8, START 0xC, BUSY 0x10); 0x3001 query; 0x3002 leaf; 0x3003 best; 0x3004 node.
// - Any other region: ack, write dropped, read returns 0.
// - FSM states IDLE, ACK, RDWAIT.
//   - IDLE: stb&cyc -> ACK, except a best read -> RDWAIT with best_ren_o=1 for one cycle.
//   - RDWAIT -> ACK.
//   - ACK: wbs_ack_o=1 for exactly one cycle -> IDLE. A stb held high starts a new transfer the next cycle, so min spacing is 2 cycles.
// - Latency: writes and CSR reads ack 1 cycle after stb; best reads ack 2 cycles after stb.
// - Memory strobes (node_/leaf_/query_wen_o) pulse in the ACK cycle; address and data are held stable in that cycle.
// - Leaf/query index = adr[IDX_W+2:3]; adr[2]=0 selects the lower half, adr[2]=1 the upper half.
//   - Lower write: hold_reg<=dat, hold_idx<=index, hold_valid<=1; no memory strobe.
//   - Upper write: commits wdata={dat,hold_reg} at the upper write's index; hold_valid<=0.
// - Node index = adr[NODE_ADDR_W-1:0]; node_wdata_o = dat[21:0]; each write commits immediately.
// - CSR writes:
//   - MODE/DEBUG <= dat[0].
//   - START: fsm_start_o=1 in the ACK cycle.
//   - DONE: clears done_sticky.
// - CSR reads: MODE/DEBUG -> {31'b0,reg}; DONE -> {30'b0,err,done_sticky}; BUSY -> {31'b0,fsm_busy_i}.
// - Best read: wbs_dat_o = zero-extended best_rdata_i.
// - fsm_done_i sets done_sticky. If it coincides with a DONE write, set wins.
// - START write while fsm_busy_i=1: pulse still issued; the FSM ignores it.
// - Deassert of stb/cyc while in RDWAIT: the transfer is aborted, no ack, return to IDLE.
// - Reset mid-transfer: immediate return to IDLE; any half-packed word is discarded.
// CONFIGURATION
// - Macro WBS_BRIDGE_ERR_EN.
// - Defined: an upper write with hold_valid=0 or index!=hold_idx is dropped (no wen) and sets sticky err. err is cleared by a DONE write.
// - Not defined: an upper write always commits with the current hold_reg; err reads 0.
// STRUCTURE
// - Package wbs_map_pkg: region/offset localparams (WBS_ADDR_MASK, WBS_*_ADDR), state enum, region-decode typedef.
// - Sub-module wbs_word_packer (hold_reg/hold_idx/hold_valid plus the commit/err decision), instantiated twice: leaf and query.
// TESTING
// - Write DEBUG=1, then MODE=1 -> wbs_mode_o=1, wbs_debug_o=1; reading MODE returns 32'h1, ack 1 cycle after stb.
// - Node write at 0x3004_0005, dat={median 55, idx 1} -> node_wen_o pulses once, node_addr_o=5, node_wdata_o=22'h1B801.
// - Leaf lower at 0x3002_0010=0x1234_5678, then upper at 0x3002_0014=0x0ABC_DEF0 -> one leaf_wen_o pulse, addr=2, wdata=64'h0ABCDEF0_12345678.
// - Best read at 0x3003_000C with best_rdata_i=11'd300 -> best_ren_o, best_addr_o=3, ack 2 cycles later, wbs_dat_o=300.
// - START write -> single-cycle fsm_start_o. Pulse fsm_done_i -> DONE reads 1. DONE write -> reads 0.
// - ERR_EN: upper write at leaf 0x3002_0024 with no prior lower -> no leaf_wen_o, DONE read bit1=1.

Source files
------------

// File: rtl/wbs_mem_bridge_pkg.sv
// wbs_map_pkg: Wishbone address map, FSM states and region decode for wbs_mem_bridge
package wbs_map_pkg;
  localparam logic [31:0] WBS_ADDR_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] WBS_CSR_ADDR   = 32'h3000_0000;
  localparam logic [31:0] WBS_QUERY_ADDR = 32'h3001_0000;
  localparam logic [31:0] WBS_LEAF_ADDR  = 32'h3002_0000;
  localparam logic [31:0] WBS_BEST_ADDR  = 32'h3003_0000;
  localparam logic [31:0] WBS_NODE_ADDR  = 32'h3004_0000;
  localparam logic [15:0] WBS_MODE_OFF   = 16'h0000;
  localparam logic [15:0] WBS_DEBUG_OFF  = 16'h0004;
  localparam logic [15:0] WBS_DONE_OFF   = 16'h0008;
  localparam logic [15:0] WBS_START_OFF  = 16'h000C;
  localparam logic [15:0] WBS_BUSY_OFF   = 16'h0010;
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RDWAIT} state_t;
  typedef enum logic [2:0] {R_CSR, R_QUERY, R_LEAF, R_BEST, R_NODE, R_NONE} region_t;
  function automatic region_t decode(input logic [31:0] adr);
    logic [31:0] b;
    b = adr & WBS_ADDR_MASK;
    return b == WBS_CSR_ADDR ? R_CSR :
           b == WBS_QUERY_ADDR ? R_QUERY :
           b == WBS_LEAF_ADDR ? R_LEAF :
           b == WBS_BEST_ADDR ? R_BEST :
           b == WBS_NODE_ADDR ? R_NODE : R_NONE;
  endfunction
endpackage

// File: rtl/wbs_mem_bridge_if.sv
// wbs_mem_bridge_if: Wishbone classic slave bus (stb/cyc/we/sel/adr/dat in, ack/dat out)
interface wbs_mem_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport slave (input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                 output wbs_ack_o, wbs_dat_o);
  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wbs_mem_bridge_packer.sv
// wbs_word_packer: joins a lower and an upper 32-bit write into one wide memory word
// Ports: wr_i/upper_i/idx_i/dat_i accepted write; commit_o/err_o/wdata_o commit decision.
// Macro WBS_BRIDGE_ERR_EN: drop and flag upper writes without a matching lower half.
module wbs_word_packer #(
  parameter int IDX_W = 9,
  parameter int OUT_W = 64
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic             upper_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      dat_i,
  output logic             commit_o,
  output logic             err_o,
  output logic [OUT_W-1:0] wdata_o
);
  logic [31:0] hold_reg;
  assign wdata_o = OUT_W'({dat_i, hold_reg});
  assign commit_o = wr_i & upper_i & ~err_o;
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) hold_reg <= '0;
    else if (wr_i && !upper_i) hold_reg <= dat_i;
`ifdef WBS_BRIDGE_ERR_EN
  logic [IDX_W-1:0] hold_idx;
  logic             hold_valid;
  assign err_o = wr_i & upper_i & (~hold_valid | (idx_i != hold_idx));
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      hold_idx   <= '0;
      hold_valid <= 1'b0;
    end else if (wr_i) begin
      hold_valid <= ~upper_i;
      if (!upper_i) hold_idx <= idx_i;
    end
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: rtl/wbs_mem_bridge.sv
// wbs_mem_bridge: Wishbone slave bridging the Caravel bus to the KD-tree memories and control
// Ports: wb_clk_i, rst_n (async low), wb (Wishbone slave), wbs_mode_o/wbs_debug_o CSR bits,
// fsm_start_o/fsm_busy_i/fsm_done_i, node/leaf/query write ports, best read port.
// Macro WBS_BRIDGE_ERR_EN: enables sticky err on unmatched upper leaf/query writes.
module wbs_mem_bridge
  import wbs_map_pkg::*;
#(
  parameter int DATA_WIDTH   = 11,
  parameter int NODE_ADDR_W  = 6,
  parameter int LEAF_ADDR_W  = 9,
  parameter int QUERY_ADDR_W = 9,
  parameter int BEST_ADDR_W  = 9
) (
  input  logic                      wb_clk_i,
  input  logic                      rst_n,
  wbs_mem_bridge_if.slave           wb,
  output logic                      wbs_mode_o,
  output logic                      wbs_debug_o,
  output logic                      fsm_start_o,
  input  logic                      fsm_busy_i,
  input  logic                      fsm_done_i,
  output logic                      node_wen_o,
  output logic [NODE_ADDR_W-1:0]    node_addr_o,
  output logic [2*DATA_WIDTH-1:0]   node_wdata_o,
  output logic                      leaf_wen_o,
  output logic [LEAF_ADDR_W-1:0]    leaf_addr_o,
  output logic [63:0]               leaf_wdata_o,
  output logic                      query_wen_o,
  output logic [QUERY_ADDR_W-1:0]   query_addr_o,
  output logic [5*DATA_WIDTH-1:0]   query_wdata_o,
  output logic                      best_ren_o,
  output logic [BEST_ADDR_W-1:0]    best_addr_o,
  input  logic [DATA_WIDTH-1:0]     best_rdata_i
);
  state_t      state;
  region_t     region;
  logic        go, wr, csr_wr, done_clr, node_wr, best_rd, best_sel;
  logic        leaf_commit, leaf_err, query_commit, query_err, done_sticky, err;
  logic [15:0] off;
  logic [31:0] csr_rdata, dat_reg;
  logic [63:0] leaf_wdata;
  logic [5*DATA_WIDTH-1:0] query_wdata;
  assign region   = decode(wb.wbs_adr_i);
  assign off      = wb.wbs_adr_i[15:0];
  assign go       = state == S_IDLE && wb.wbs_stb_i && wb.wbs_cyc_i;
  assign wr       = go && wb.wbs_we_i && wb.wbs_sel_i == 4'hF;
  assign csr_wr   = wr && region == R_CSR;
  assign done_clr = csr_wr && off == WBS_DONE_OFF;
  assign node_wr  = wr && region == R_NODE;
  assign best_rd  = go && !wb.wbs_we_i && region == R_BEST;
  assign csr_rdata = off == WBS_MODE_OFF  ? {31'b0, wbs_mode_o} :
                     off == WBS_DEBUG_OFF ? {31'b0, wbs_debug_o} :
                     off == WBS_DONE_OFF  ? {30'b0, err, done_sticky} :
                     off == WBS_BUSY_OFF  ? {31'b0, fsm_busy_i} : 32'b0;
  // best data arrives straight from the memory during the ACK cycle
  assign wb.wbs_dat_o = best_sel ? {{(32-DATA_WIDTH){1'b0}}, best_rdata_i} : dat_reg;
  wbs_word_packer #(.IDX_W(LEAF_ADDR_W), .OUT_W(64)) u_leaf (
    .wb_clk_i, .rst_n, .wr_i(wr && region == R_LEAF), .upper_i(wb.wbs_adr_i[2]),
    .idx_i(wb.wbs_adr_i[LEAF_ADDR_W+2:3]), .dat_i(wb.wbs_dat_i),
    .commit_o(leaf_commit), .err_o(leaf_err), .wdata_o(leaf_wdata));
  wbs_word_packer #(.IDX_W(QUERY_ADDR_W), .OUT_W(5*DATA_WIDTH)) u_query (
    .wb_clk_i, .rst_n, .wr_i(wr && region == R_QUERY), .upper_i(wb.wbs_adr_i[2]),
    .idx_i(wb.wbs_adr_i[QUERY_ADDR_W+2:3]), .dat_i(wb.wbs_dat_i),
    .commit_o(query_commit), .err_o(query_err), .wdata_o(query_wdata));
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      wb.wbs_ack_o <= 1'b0;
      dat_reg      <= '0;
      best_sel     <= 1'b0;
      wbs_mode_o   <= 1'b0;
      wbs_debug_o  <= 1'b0;
      fsm_start_o  <= 1'b0;
      done_sticky  <= 1'b0;
      err          <= 1'b0;
      node_wen_o   <= 1'b0;
      node_addr_o  <= '0;
      node_wdata_o <= '0;
      leaf_wen_o   <= 1'b0;
      leaf_addr_o  <= '0;
      leaf_wdata_o <= '0;
      query_wen_o  <= 1'b0;
      query_addr_o <= '0;
      query_wdata_o <= '0;
      best_ren_o   <= 1'b0;
      best_addr_o  <= '0;
    end else begin
      wb.wbs_ack_o <= 1'b0;
      dat_reg      <= '0;
      best_sel     <= 1'b0;
      best_ren_o   <= 1'b0;
      fsm_start_o  <= csr_wr && off == WBS_START_OFF;
      node_wen_o   <= node_wr;
      leaf_wen_o   <= leaf_commit;
      query_wen_o  <= query_commit;
      done_sticky  <= fsm_done_i || (done_sticky && !done_clr);
      err          <= leaf_err || query_err || (err && !done_clr);
      if (csr_wr && off == WBS_MODE_OFF) wbs_mode_o <= wb.wbs_dat_i[0];
      if (csr_wr && off == WBS_DEBUG_OFF) wbs_debug_o <= wb.wbs_dat_i[0];
      if (node_wr) begin
        node_addr_o  <= wb.wbs_adr_i[NODE_ADDR_W-1:0];
        node_wdata_o <= wb.wbs_dat_i[2*DATA_WIDTH-1:0];
      end
      if (leaf_commit) begin
        leaf_addr_o  <= wb.wbs_adr_i[LEAF_ADDR_W+2:3];
        leaf_wdata_o <= leaf_wdata;
      end
      if (query_commit) begin
        query_addr_o  <= wb.wbs_adr_i[QUERY_ADDR_W+2:3];
        query_wdata_o <= query_wdata;
      end
      if (state == S_IDLE) begin
        if (best_rd) begin
          state       <= S_RDWAIT;
          best_ren_o  <= 1'b1;
          best_addr_o <= wb.wbs_adr_i[BEST_ADDR_W+1:2];
        end else if (go) begin
          state        <= S_ACK;
          wb.wbs_ack_o <= 1'b1;
          dat_reg      <= !wb.wbs_we_i && region == R_CSR ? csr_rdata : 32'b0;
        end
      end else if (state == S_RDWAIT) begin
        state        <= wb.wbs_stb_i && wb.wbs_cyc_i ? S_ACK : S_IDLE;
        wb.wbs_ack_o <= wb.wbs_stb_i && wb.wbs_cyc_i;
        best_sel     <= wb.wbs_stb_i && wb.wbs_cyc_i;
      end else state <= S_IDLE;
    end
endmodule

// File: tb/tb_wbs_mem_bridge.sv
// tb_wbs_mem_bridge: scoreboard testbench for wbs_mem_bridge
module tb_wbs_mem_bridge;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  wbs_mem_bridge_if wb();
  logic        mode_o, debug_o, start_o, node_wen, leaf_wen, query_wen, best_ren;
  logic        busy = 0, done = 0;
  logic [5:0]  node_addr;
  logic [21:0] node_wdata;
  logic [8:0]  leaf_addr, query_addr, best_addr;
  logic [63:0] leaf_wdata;
  logic [54:0] query_wdata;
  logic [10:0] best_rdata = 0;
  logic [10:0] best_mem [512];
  wbs_mem_bridge dut (
    .wb_clk_i(clk), .rst_n(rst_n), .wb(wb),
    .wbs_mode_o(mode_o), .wbs_debug_o(debug_o), .fsm_start_o(start_o),
    .fsm_busy_i(busy), .fsm_done_i(done),
    .node_wen_o(node_wen), .node_addr_o(node_addr), .node_wdata_o(node_wdata),
    .leaf_wen_o(leaf_wen), .leaf_addr_o(leaf_addr), .leaf_wdata_o(leaf_wdata),
    .query_wen_o(query_wen), .query_addr_o(query_addr), .query_wdata_o(query_wdata),
    .best_ren_o(best_ren), .best_addr_o(best_addr), .best_rdata_i(best_rdata));
  always @(posedge clk) if (best_ren) best_rdata <= best_mem[best_addr];
  typedef struct {int lat; logic rd; logic [31:0] d;} ack_t;
  typedef struct {logic [8:0] a; logic [63:0] d;} mem_t;
  ack_t q_ack[$];
  mem_t q_node[$], q_leaf[$], q_query[$];
  logic [8:0] q_best[$];
  int errors = 0, checks = 0, exp_start = 0, seen_start = 0, lat = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    ack_t e;
    mem_t m;
    if (wb.wbs_ack_o) begin
      if (q_ack.size() == 0) chk("unexpected_ack", wb.wbs_ack_o, 0);
      else begin
        e = q_ack.pop_front();
        chk("ack_latency", lat, e.lat);
        if (e.rd) chk("rdata", wb.wbs_dat_o, e.d);
      end
      lat = 0;
    end else lat = (wb.wbs_stb_i && wb.wbs_cyc_i) ? lat + 1 : 0;
    if (node_wen) begin
      if (q_node.size() == 0) chk("unexpected_node_wen", node_wen, 0);
      else begin m = q_node.pop_front(); chk("node_addr", node_addr, m.a); chk("node_wdata", node_wdata, m.d); end
    end
    if (leaf_wen) begin
      if (q_leaf.size() == 0) chk("unexpected_leaf_wen", leaf_wen, 0);
      else begin m = q_leaf.pop_front(); chk("leaf_addr", leaf_addr, m.a); chk("leaf_wdata", leaf_wdata, m.d); end
    end
    if (query_wen) begin
      if (q_query.size() == 0) chk("unexpected_query_wen", query_wen, 0);
      else begin m = q_query.pop_front(); chk("query_addr", query_addr, m.a); chk("query_wdata", query_wdata, m.d); end
    end
    if (best_ren) begin
      if (q_best.size() == 0) chk("unexpected_best_ren", best_ren, 0);
      else chk("best_addr", best_addr, q_best.pop_front());
    end
    if (start_o) seen_start++;
  end
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = we; wb.wbs_adr_i = a; wb.wbs_dat_i = d; wb.wbs_sel_i = s;
    do begin @(posedge clk); #1; n++; end while (!wb.wbs_ack_o && n < 6);
    if (!wb.wbs_ack_o) chk("ack_timeout", wb.wbs_ack_o, 1);
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    q_ack.push_back('{1, 1'b0, 32'h0});
    xfer(1, a, d, s);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int l);
    q_ack.push_back('{l, 1'b1, exp});
    xfer(0, a, 32'h0, 4'hF);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 512; i++) best_mem[i] = 11'(i * 7);
    best_mem[3] = 11'd300;
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0; wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", wb.wbs_ack_o, 0);
    chk("rst_dat", wb.wbs_dat_o, 0);
    chk("rst_outs", {mode_o, debug_o, start_o, node_wen, leaf_wen, query_wen, best_ren}, 0);
    rst_n = 1;
    wr(32'h3000_0004, 1, 4'hF);
    wr(32'h3000_0000, 1, 4'hF);
    chk("mode_o", mode_o, 1);
    chk("debug_o", debug_o, 1);
    rd(32'h3000_0000, 32'h1, 1);
    rd(32'h3000_0004, 32'h1, 1);
    wr(32'h3000_0000, 0, 4'h3);
    chk("mode_sel_ignored", mode_o, 1);
    q_node.push_back('{9'd5, 64'h1B801});
    wr(32'h3004_0005, 32'h0001_B801, 4'hF);
    wr(32'h3002_0010, 32'h1234_5678, 4'hF);
    q_leaf.push_back('{9'd2, 64'h0ABCDEF0_12345678});
    wr(32'h3002_0014, 32'h0ABC_DEF0, 4'hF);
    wr(32'h3001_0008, 32'hAAAA_5555, 4'hF);
    q_query.push_back('{9'd1, 64'h007F_FFFF_AAAA_5555});
    wr(32'h3001_000C, 32'h7FFF_FFFF, 4'hF);
    q_best.push_back(9'd3);
    rd(32'h3003_000C, 32'd300, 2);
    q_best.push_back(9'd8);
    @(posedge clk); #1;
    wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = 0; wb.wbs_adr_i = 32'h3003_0020;
    @(posedge clk); #1;
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0;
    repeat (3) @(posedge clk);
    q_best.push_back(9'd5);
    rd(32'h3003_0014, 32'd35, 2);
    exp_start++;
    wr(32'h3000_000C, 1, 4'hF);
    busy = 1;
    exp_start++;
    wr(32'h3000_000C, 1, 4'hF);
    rd(32'h3000_0010, 32'h1, 1);
    busy = 0;
    rd(32'h3000_0010, 32'h0, 1);
    rd(32'h3000_0008, 32'h0, 1);
    @(posedge clk); #1 done = 1;
    @(posedge clk); #1 done = 0;
    rd(32'h3000_0008, 32'h1, 1);
    wr(32'h3000_0008, 0, 4'hF);
    rd(32'h3000_0008, 32'h0, 1);
    done = 1;
    wr(32'h3000_0008, 0, 4'hF);
    done = 0;
    rd(32'h3000_0008, 32'h1, 1);
    wr(32'h3000_0008, 0, 4'hF);
`ifdef WBS_BRIDGE_ERR_EN
    wr(32'h3002_0024, 32'h5555_AAAA, 4'hF);
    rd(32'h3000_0008, 32'h2, 1);
    wr(32'h3000_0008, 0, 4'hF);
`else
    q_leaf.push_back('{9'd4, 64'h5555AAAA_12345678});
    wr(32'h3002_0024, 32'h5555_AAAA, 4'hF);
`endif
    rd(32'h3000_0008, 32'h0, 1);
    wr(32'h3005_0000, 32'hFFFF_FFFF, 4'hF);
    rd(32'h3005_0000, 32'h0, 1);
    rd(32'h3002_0010, 32'h0, 1);
    wr(32'h3002_0030, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1 rst_n = 0;
    #2;
    chk("async_rst_mode", mode_o, 0);
    @(posedge clk); #1 rst_n = 1;
`ifdef WBS_BRIDGE_ERR_EN
    wr(32'h3002_0034, 32'h1111_2222, 4'hF);
    rd(32'h3000_0008, 32'h2, 1);
`else
    q_leaf.push_back('{9'd6, 64'h11112222_00000000});
    wr(32'h3002_0034, 32'h1111_2222, 4'hF);
    rd(32'h3000_0008, 32'h0, 1);
`endif
    repeat (4) @(posedge clk);
    chk("start_pulses", seen_start, exp_start);
    chk("ack_pending", q_ack.size(), 0);
    chk("node_pending", q_node.size(), 0);
    chk("leaf_pending", q_leaf.size(), 0);
    chk("query_pending", q_query.size(), 0);
    chk("best_pending", q_best.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
